// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Delivered-word and stall-cycle counters for the fetch stage; both wrap.
module fetch_perf_counters (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WordDelivered,
  input  logic        Stall,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCycles
);

  logic [31:0] fetch_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_count_q  <= 32'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      if (WordDelivered) fetch_count_q <= fetch_count_q + 32'd1;
      if (Stall)         stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign FetchCount  = fetch_count_q;
  assign StallCycles = stall_cycles_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, talks req/ack to instruction memory and drives the
// Fetch-To-Decode register with stall/flush applied. Option: FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] PCAddResult,
  output logic [31:0] Instruction,
  output logic        FetchValid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCycles
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_word_q, hold_word_d;
  logic [31:0]  hold_pcadd_q, hold_pcadd_d;
  logic [31:0]  pending_q, pending_d;
  logic [31:0]  pcadd_q, pcadd_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;

  logic         ack;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         deliver;
  logic [31:0]  deliver_word;
  logic [31:0]  deliver_pcadd;

  // Request drops straight away while Reset is low, abandoning any transfer.
  assign IMemReq  = Reset && (state_q != S_HOLD);
  // PC is not advanced while a request is in flight, so it is the fetch address.
  assign IMemAddr = pc_q;

  assign ack      = IMemAck && IMemReq;
  assign target   = word_align(RedirectTarget);
  assign pc_plus4 = pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_word_d   = hold_word_q;
    hold_pcadd_d  = hold_pcadd_q;
    pending_d     = pending_q;
    deliver       = 1'b0;
    deliver_word  = NOP_WORD;
    deliver_pcadd = 32'd0;

    unique case (state_q)
      S_REQ: begin
        if (ack && Redirect) begin
          pc_d = target;
        end else if (ack && Stall) begin
          hold_word_d  = IMemRdata;
          hold_pcadd_d = pc_plus4;
          state_d      = S_HOLD;
        end else if (ack) begin
          deliver       = 1'b1;
          deliver_word  = IMemRdata;
          deliver_pcadd = pc_plus4;
          pc_d          = pc_plus4;
        end else if (Redirect) begin
          pending_d = target;
          state_d   = S_DROP;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!Stall) begin
          deliver       = 1'b1;
          deliver_word  = hold_word_q;
          deliver_pcadd = hold_pcadd_q;
          pc_d          = hold_pcadd_q;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (Redirect) pending_d = target;
        if (ack) begin
          pc_d    = Redirect ? target : pending_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pcadd_d = pcadd_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (Redirect) begin
      pcadd_d = 32'd0;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (!Stall) begin
      pcadd_d = deliver_pcadd;
      instr_d = deliver_word;
      valid_d = deliver;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_REQ;
      pc_q         <= word_align(RESET_PC);
      hold_word_q  <= 32'd0;
      hold_pcadd_q <= 32'd0;
      pending_q    <= 32'd0;
      pcadd_q      <= 32'd0;
      instr_q      <= NOP_WORD;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_word_q  <= hold_word_d;
      hold_pcadd_q <= hold_pcadd_d;
      pending_q    <= pending_d;
      pcadd_q      <= pcadd_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

  assign PCAddResult = pcadd_q;
  assign Instruction = instr_q;
  assign FetchValid  = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
  fetch_perf_counters u_perf (
    .Clk           (Clk),
    .Reset         (Reset),
    .WordDelivered (deliver && !Redirect && !Stall),
    .Stall         (Stall),
    .FetchCount    (FetchCount),
    .StallCycles   (StallCycles)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = 32'd0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRdata = 32'd0;

  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, pcadd0, pcadd1, instr0, instr1;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  always #5 Clk = ~Clk;

  instruction_fetch_unit dut0 (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMemReq        (req0),
    .IMemAddr       (addr0),
    .IMemAck        (IMemAck),
    .IMemRdata      (IMemRdata),
    .PCAddResult    (pcadd0),
    .Instruction    (instr0),
    .FetchValid     (valid0)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .FetchCount     (fc0),
    .StallCycles    (sc0)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut1 (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMemReq        (req1),
    .IMemAddr       (addr1),
    .IMemAck        (IMemAck),
    .IMemRdata      (IMemRdata),
    .PCAddResult    (pcadd1),
    .Instruction    (instr1),
    .FetchValid     (valid1)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .FetchCount     (fc1),
    .StallCycles    (sc1)
`endif
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: next fetch address, an optional held word, an optional
  // abandoned in-flight request with its replacement target, and the outputs.
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_held_word;
  bit          m_dropping;
  logic [31:0] m_drop_tgt;
  logic [31:0] m_pcadd, m_instr;
  logic        m_valid;
  logic [31:0] m_fcnt, m_scnt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_held = 0; m_held_word = 32'd0; m_dropping = 0; m_drop_tgt = 32'd0;
    m_pcadd = 32'd0; m_instr = NOP; m_valid = 1'b0; m_fcnt = 32'd0; m_scnt = 32'd0;
  endtask

  task automatic check_all();
    chk("req", 32'(req0), 32'(!m_held));
    if (!m_held) chk("addr", addr0, m_pc);
    chk("pcadd", pcadd0, m_pcadd);
    chk("instr", instr0, m_instr);
    chk("valid", 32'(valid0), 32'(m_valid));
`ifdef FETCH_PERF_COUNTERS_EN
    chk("fetch_count", fc0, m_fcnt);
    chk("stall_cycles", sc0, m_scnt);
`endif
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tg, input bit ak);
    logic [31:0] t;
    bit          took;
    bit          dlv;
    logic [31:0] dw, dp;
    Stall = st; Redirect = rd; RedirectTarget = tg; IMemAck = ak; IMemRdata = mem(m_pc);
    @(posedge Clk);
    t    = {tg[31:2], 2'b00};
    took = ak && !m_held;
    dlv  = 0; dw = NOP; dp = 32'd0;
    if (m_held) begin
      if (rd) begin
        m_held = 0; m_pc = t;
      end else if (!st) begin
        dlv = 1; dw = m_held_word; dp = m_pc + 32'd4; m_held = 0; m_pc = m_pc + 32'd4;
      end
    end else if (m_dropping) begin
      if (took) begin
        m_pc = rd ? t : m_drop_tgt; m_dropping = 0;
      end else if (rd) begin
        m_drop_tgt = t;
      end
    end else if (took) begin
      if (rd) m_pc = t;
      else if (st) begin
        m_held = 1; m_held_word = mem(m_pc);
      end else begin
        dlv = 1; dw = mem(m_pc); dp = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end
    end else if (rd) begin
      m_dropping = 1; m_drop_tgt = t;
    end
    if (rd) begin
      m_pcadd = 32'd0; m_instr = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_pcadd = dp; m_instr = dw; m_valid = dlv;
    end
    if (st) m_scnt = m_scnt + 32'd1;
    if (dlv) m_fcnt = m_fcnt + 32'd1;
    #1;
    check_all();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, 32'(req0), 32'd0);
    chk({tag, "_pcadd"}, pcadd0, 32'd0);
    chk({tag, "_instr"}, instr0, NOP);
    chk({tag, "_valid"}, 32'(valid0), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk({tag, "_fetch_count"}, fc0, 32'd0);
    chk({tag, "_stall_cycles"}, sc0, 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    #1;
    chk("rel_req", 32'(req0), 32'd1);
    chk("rel_addr", addr0, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    reset_checks("rst");
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);
    release_reset();

    // Zero-wait-state fetches; the wrap instance delivers PC+4 = 0.
    step(0, 0, 32'd0, 1);
    chk("t1_instr0", instr0, 32'h11);
    chk("t5_pcadd1", pcadd1, 32'd0);
    chk("t5_valid1", 32'(valid1), 32'd1);
    chk("t5_addr1", addr1, 32'd0);
    step(0, 0, 32'd0, 1);
    chk("t1_instr1", instr0, 32'h22);

    // Stall while the word at PC 8 is acked, then release.
    step(1, 0, 32'd0, 1);
    chk("t2_hold_pcadd", pcadd0, 32'd8);
    step(1, 0, 32'd0, 1);
    step(1, 0, 32'd0, 1);
    step(0, 0, 32'd0, 0);
    chk("t2_release", instr0, 32'h33);
    chk("t2_release_pcadd", pcadd0, 32'd12);
    step(0, 0, 32'd0, 0);
    chk("t2_once", 32'(valid0), 32'd0);

    // Redirect with the request still pending on slow memory.
    step(0, 1, 32'h0000_0101, 0);
    step(0, 0, 32'd0, 0);
    chk("t3_old_addr", addr0, 32'd12);
    step(0, 0, 32'd0, 1);
    chk("t3_new_addr", addr0, 32'h100);
    step(0, 0, 32'd0, 1);

    // Redirect together with Stall, both on an ack and from the hold state.
    step(1, 1, 32'h200, 1);
    step(1, 0, 32'd0, 1);
    step(1, 1, 32'h300, 0);
    chk("t4_addr", addr0, 32'h300);

    // Reset arrives in the middle of a dropped request.
    step(0, 1, 32'h400, 0);
    #2;
    Reset = 1'b0;
    #1;
    reset_checks("t6");
    release_reset();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
